// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage, the instruction ROM and the decoder.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              stall;
    logic              branch_taken;
    logic [15:0]       branch_imm;
    logic              jump;
    logic [25:0]       jump_index;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid, halted,
        input  rom_data, stall, branch_taken, branch_imm, jump, jump_index
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid, halted,
        output rom_data, stall, branch_taken, branch_imm, jump, jump_index
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches ROM words into the IR,
// and handles stall, branch/jump redirect with flush, and SYSCALL halt.
module fetch_unit #(
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [31:0]       HALT_WORD = 32'h0000000C
) (
    input logic            clk,
    input logic            rst_n,
    fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

    state_t            state_r, state_n;
    logic [ADDR_W-1:0] pc_r, pc_n;
    logic [31:0]       ir_r, ir_n;
    logic [ADDR_W-1:0] ipc_r, ipc_n;
    logic              valid_r, valid_n;
    logic              halted_r, halted_n;
    logic              redirect_s;
    logic [ADDR_W-1:0] target_s;

    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] ipc,
        input logic [15:0]       imm
    );
        return ipc + PC_STEP + ADDR_W'({{14{imm[15]}}, imm, 2'b00});
    endfunction

    // Upper nibble of pc4 only matters when the address space exceeds 28 bits.
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [ADDR_W-1:0] ipc,
        input logic [25:0]       index
    );
        return ADDR_W'(((32'(ipc) + 32'd4) & 32'hF000_0000) | {4'h0, index, 2'b00});
    endfunction

    assign redirect_s = bus.branch_taken | bus.jump;
    assign target_s   = bus.jump ? jump_target(ipc_r, bus.jump_index)
                                 : branch_target(ipc_r, bus.branch_imm);

    // Next-state and next-register selection: redirect > stall > halt check > fetch.
    always_comb begin
        state_n  = state_r;
        pc_n     = pc_r;
        ir_n     = ir_r;
        ipc_n    = ipc_r;
        valid_n  = valid_r;
        halted_n = halted_r;
        case (state_r)
            ST_EMPTY: begin
                ir_n    = bus.rom_data;
                ipc_n   = pc_r;
                valid_n = 1'b1;
                pc_n    = pc_r + PC_STEP;
                state_n = ST_VALID;
            end
            ST_VALID: begin
                if (redirect_s) begin
                    pc_n    = {target_s[ADDR_W-1:2], 2'b00};
                    ir_n    = 32'h0000_0000;
                    valid_n = 1'b0;
                    state_n = ST_EMPTY;
                end else if (bus.stall) begin
                    state_n = ST_VALID;
                end else if (ir_r == HALT_WORD) begin
                    ir_n     = 32'h0000_0000;
                    valid_n  = 1'b0;
                    halted_n = 1'b1;
                    state_n  = ST_HALT;
                end else begin
                    ir_n    = bus.rom_data;
                    ipc_n   = pc_r;
                    valid_n = 1'b1;
                    pc_n    = pc_r + PC_STEP;
                    state_n = ST_VALID;
                end
            end
            ST_HALT: begin
                ir_n     = 32'h0000_0000;
                valid_n  = 1'b0;
                halted_n = 1'b1;
                state_n  = ST_HALT;
            end
            default: begin
                ir_n     = 32'h0000_0000;
                valid_n  = 1'b0;
                halted_n = 1'b0;
                state_n  = ST_EMPTY;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_EMPTY;
            pc_r     <= RESET_PC;
            ir_r     <= 32'h0000_0000;
            ipc_r    <= {ADDR_W{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            pc_r     <= pc_n;
            ir_r     <= ir_n;
            ipc_r    <= ipc_n;
            valid_r  <= valid_n;
            halted_r <= halted_n;
        end
    end

    assign bus.rom_addr    = pc_r;
    assign bus.instr       = ir_r;
    assign bus.instr_pc    = ipc_r;
    assign bus.instr_valid = valid_r;
    assign bus.halted      = halted_r;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 16-byte instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the returned 32-bit word into an instruction register (IR) for the decoder.
- Handles stall, branch/jump redirect with flush, and a SYSCALL-triggered halt.

Parameters:
- ADDR_W, 4, byte-address width of the instruction ROM; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- HALT_WORD, 32'h0000000C, instruction encoding (SYSCALL) that halts fetch.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rom_addr  out  ADDR_W  byte address to ROM; always equals pc_q, bits [1:0] always 0
- rom_data  in  32  instruction word from ROM (combinational, same cycle)
- stall  in  1  decoder cannot accept; hold PC and IR
- branch_taken  in  1  redirect to branch target (refers to instruction in IR)
- branch_imm  in  16  signed word offset of the branch
- jump  in  1  redirect to jump target
- jump_index  in  26  J-type index field
- instr  out  32  IR contents; 32'h0 whenever instr_valid=0
- instr_pc  out  ADDR_W  byte address the IR word was fetched from
- instr_valid  out  1  IR holds a live instruction
- halted  out  1  fetch permanently stopped until reset

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, IR=0, instr_pc=0, instr_valid=0, halted=0, state=EMPTY.
  - Takes effect mid-operation immediately, regardless of state.
- States:
  - EMPTY: IR invalid.
  - VALID: IR live.
  - HALT: fetch frozen.
- Priority at each rising edge, outside HALT: redirect > stall > normal fetch.
- Redirect (branch_taken or jump, evaluated only when instr_valid=1):
  - Branch target = instr_pc + 4 + (sext(branch_imm) << 2), truncated to ADDR_W.
  - Jump target = low ADDR_W bits of {pc4[31:28], jump_index, 2'b00}, where pc4 = zero-extended instr_pc + 4.
  - If both branch_taken and jump are set, jump wins.
  - pc_q <= target with bits [1:0] forced to 0; IR flushed (instr=0, instr_valid=0); state -> EMPTY.
  - A redirect overrides stall.
  - Redirect inputs are ignored when instr_valid=0.
- Stall (no redirect):
  - VALID: pc_q, IR, instr_pc held.
  - EMPTY: stall is ignored and a normal fetch occurs.
- Normal fetch:
  - IR <= rom_data, instr_pc <= pc_q, instr_valid <= 1, pc_q <= pc_q + 4 (wraps, e.g. 4'hC -> 4'h0); state -> VALID.
- Fetch latency: word at address A appears on instr exactly one edge after rom_addr=A.
- Halt:
  - The edge where state=VALID, instr==HALT_WORD, stall=0 and no redirect moves state to HALT.
  - In HALT: instr_valid=0, instr=0, halted=1, pc_q frozen; stall and redirect ignored; only reset exits.
  - A redirect in the same cycle as a valid HALT_WORD takes priority and no halt occurs.
  - A stalled HALT_WORD stays in IR with instr_valid=1 until stall drops.
- Outputs are registered; no combinational path from stall/branch/jump to any output.

Test Plan:
- ROM = {0x11111111, 0x22222222, 0x33333333, 0x44444444}, no stall: release reset -> instr_valid=0 first cycle, then instr=0x11111111/pc 0, 0x22222222/pc 4, 0x33333333/pc 8, 0x44444444/pc C, 0x11111111/pc 0 (wrap).
- Stall asserted 3 cycles while instr=0x22222222 -> instr, instr_pc=4, rom_addr=8 all constant; on release, next edge shows 0x33333333.
- instr_pc=4, branch_taken=1, branch_imm=16'hFFFE -> next edge instr_valid=0, rom_addr=0; following edge instr=0x11111111, instr_pc=0.
- branch_taken=1 and jump=1 with jump_index=3, stall=1 -> jump wins over branch and stall: rom_addr=C, one bubble, then 0x44444444.
- Word 8 = 0x0000000C -> instr shows it one cycle with valid=1, then halted=1, instr_valid=0, rom_addr frozen at C for 10+ cycles; rst_n pulse low mid-halt -> halted=0, restart from pc 0.
- rst_n asserted between edges while VALID -> outputs reach reset values without waiting for a clock edge.
